// File: rtl/sample_phase_meter_pkg.sv
// Shared definitions for the sample phase meter and the precharge/AZ sequencer.
package sample_phase_meter_pkg;

  // The encoding is visible on monitor[2:0], so debug tooling relies on these values.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PRE  = 3'd2,
    ST_HI   = 3'd3,
    ST_POST = 3'd4,
    ST_LO   = 3'd5
  } state_t;

  localparam logic SW_PC_SIGNAL = 1'b1;
  localparam logic SW_PC_BOOT   = 1'b0;

endpackage

// File: rtl/sample_phase_meter_edge_det.sv
// Registered-delay edge detector: rise/fall are seen in the same cycle the input changes.
module sample_phase_meter_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic rise,
  output logic fall
);

  logic x_q;
  logic x_d;

  always_comb begin
    x_d = x;
  end

  // Reset loads the live input so no spurious edge appears when reset is released.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      x_q <= x;
    end else begin
      x_q <= x_d;
    end
  end

  assign rise = x & ~x_q;
  assign fall = ~x & x_q;

endmodule

// File: rtl/sample_phase_meter.sv
// Measures the duration of each phase of every acquisition cycle and emits one
// record per cycle over a valid/ack handshake; flags stalls and illegal edge order.
module sample_phase_meter
  import sample_phase_meter_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sw_pc_ctl,
  input  logic          phase_hi,
  input  logic [W-1:0]  p_timeout,
  input  logic          fault_clr,
  input  logic          rec_ack,
  output logic          rec_valid,
  output logic [W-1:0]  rec_pc,
  output logic [W-1:0]  rec_hi,
  output logic [W-1:0]  rec_post,
  output logic [W-1:0]  rec_lo,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] overrun_count,
  output logic          fault_timeout,
  output logic          fault_seq,
  output logic [7:0]    monitor
);

  logic sw_rise, sw_fall, ph_rise, ph_fall;

  sample_phase_meter_edge_det u_sw_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (sw_pc_ctl),
    .rise    (sw_rise),
    .fall    (sw_fall)
  );

  sample_phase_meter_edge_det u_ph_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (phase_hi),
    .rise    (ph_rise),
    .fall    (ph_fall)
  );

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  pc_q, pc_d, hi_q, hi_d, post_q, post_d;
  logic [W-1:0]  rec_pc_q, rec_pc_d, rec_hi_q, rec_hi_d;
  logic [W-1:0]  rec_post_q, rec_post_d, rec_lo_q, rec_lo_d;
  logic          rec_valid_q, rec_valid_d;
  logic [CW-1:0] cyc_q, cyc_d, ovr_q, ovr_d;
  logic          ft_q, ft_d, fs_q, fs_d;
  logic          seq_err, to_err, emit;
  logic          measuring;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + W'(1);
    pc_d        = pc_q;
    hi_d        = hi_q;
    post_d      = post_q;
    rec_pc_d    = rec_pc_q;
    rec_hi_d    = rec_hi_q;
    rec_post_d  = rec_post_q;
    rec_lo_d    = rec_lo_q;
    rec_valid_d = rec_valid_q;
    cyc_d       = cyc_q;
    ovr_d       = ovr_q;
    emit        = 1'b0;
    seq_err     = 1'b0;
    to_err      = 1'b0;
    measuring   = state_q inside {ST_PRE, ST_HI, ST_POST, ST_LO};

    if (state_q != ST_IDLE && sw_rise &&
        (!phase_hi || state_q inside {ST_SYNC, ST_POST, ST_LO})) begin
      seq_err = 1'b1;
    end
    if (state_q inside {ST_PRE, ST_HI} && ph_fall) begin
      seq_err = 1'b1;
    end
    if (measuring && p_timeout != '0 && cnt_q == p_timeout) begin
      to_err = 1'b1;
    end

    if (seq_err || to_err) begin
      state_d = ST_IDLE;
    end else begin
      // Each closing edge latches the running count and restarts it at 1 for the next phase.
      case (state_q)
        ST_IDLE: if (!phase_hi && !sw_pc_ctl) state_d = ST_SYNC;
        ST_SYNC: if (ph_rise) begin
          state_d = ST_PRE;
          cnt_d   = W'(1);
        end
        ST_PRE: if (sw_rise) begin
          pc_d    = cnt_q;
          state_d = ST_HI;
          cnt_d   = W'(1);
        end
        ST_HI: if (sw_fall) begin
          hi_d    = cnt_q;
          state_d = ST_POST;
          cnt_d   = W'(1);
        end
        ST_POST: if (ph_fall) begin
          post_d  = cnt_q;
          state_d = ST_LO;
          cnt_d   = W'(1);
        end
        ST_LO: if (ph_rise) begin
          emit    = 1'b1;
          state_d = ST_PRE;
          cnt_d   = W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (emit) begin
      if (!rec_valid_q || rec_ack) begin
        rec_pc_d    = pc_q;
        rec_hi_d    = hi_q;
        rec_post_d  = post_q;
        rec_lo_d    = cnt_q;
        rec_valid_d = 1'b1;
        cyc_d       = cyc_q + CW'(1);
      end else if (ovr_q != '1) begin
        ovr_d = ovr_q + CW'(1);
      end
    end else if (rec_valid_q && rec_ack) begin
      rec_valid_d = 1'b0;
    end

    // A fault raised in the same cycle as fault_clr must survive the clear.
    ft_d = (fault_clr ? 1'b0 : ft_q) | to_err;
    fs_d = (fault_clr ? 1'b0 : fs_q) | seq_err;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pc_q        <= '0;
      hi_q        <= '0;
      post_q      <= '0;
      rec_pc_q    <= '0;
      rec_hi_q    <= '0;
      rec_post_q  <= '0;
      rec_lo_q    <= '0;
      rec_valid_q <= 1'b0;
      cyc_q       <= '0;
      ovr_q       <= '0;
      ft_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      hi_q        <= hi_d;
      post_q      <= post_d;
      rec_pc_q    <= rec_pc_d;
      rec_hi_q    <= rec_hi_d;
      rec_post_q  <= rec_post_d;
      rec_lo_q    <= rec_lo_d;
      rec_valid_q <= rec_valid_d;
      cyc_q       <= cyc_d;
      ovr_q       <= ovr_d;
      ft_q        <= ft_d;
      fs_q        <= fs_d;
    end
  end

  assign rec_valid     = rec_valid_q;
  assign rec_pc        = rec_pc_q;
  assign rec_hi        = rec_hi_q;
  assign rec_post      = rec_post_q;
  assign rec_lo        = rec_lo_q;
  assign cycle_count   = cyc_q;
  assign overrun_count = ovr_q;
  assign fault_timeout = ft_q;
  assign fault_seq     = fs_q;
  assign monitor       = {2'b00, rec_valid_q, ph_fall, ph_rise, state_q};

endmodule

// File: tb/tb_sample_phase_meter.sv
// Directed bench for sample_phase_meter: records go through a scoreboard queue,
// fault, reset and saturation behaviour are checked inline.
module tb_sample_phase_meter;
  import sample_phase_meter_pkg::*;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          sw_pc_ctl = SW_PC_BOOT;
  logic          phase_hi = 1'b0;
  logic [W-1:0]  p_timeout = '0;
  logic          fault_clr = 1'b0;
  logic          rec_ack = 1'b0;
  logic          rec_valid;
  logic [W-1:0]  rec_pc, rec_hi, rec_post, rec_lo;
  logic [CW-1:0] cycle_count, overrun_count;
  logic          fault_timeout, fault_seq;
  logic [7:0]    monitor;

  logic          sw8 = SW_PC_BOOT;
  logic          ph8 = 1'b0;
  logic [W8-1:0] p_timeout8 = '0;
  logic          rec_valid8;
  logic [W8-1:0] rec_pc8, rec_hi8, rec_post8, rec_lo8;
  logic [CW-1:0] cycle_count8, overrun_count8;
  logic          fault_timeout8, fault_seq8;
  logic [7:0]    monitor8;

  always #5 clk = ~clk;

  sample_phase_meter #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sw_pc_ctl(sw_pc_ctl), .phase_hi(phase_hi),
    .p_timeout(p_timeout), .fault_clr(fault_clr), .rec_ack(rec_ack),
    .rec_valid(rec_valid), .rec_pc(rec_pc), .rec_hi(rec_hi), .rec_post(rec_post),
    .rec_lo(rec_lo), .cycle_count(cycle_count), .overrun_count(overrun_count),
    .fault_timeout(fault_timeout), .fault_seq(fault_seq), .monitor(monitor)
  );

  sample_phase_meter #(.W(W8), .CW(CW)) dut8 (
    .clk(clk), .reset_n(reset_n), .sw_pc_ctl(sw8), .phase_hi(ph8),
    .p_timeout(p_timeout8), .fault_clr(1'b0), .rec_ack(1'b0),
    .rec_valid(rec_valid8), .rec_pc(rec_pc8), .rec_hi(rec_hi8), .rec_post(rec_post8),
    .rec_lo(rec_lo8), .cycle_count(cycle_count8), .overrun_count(overrun_count8),
    .fault_timeout(fault_timeout8), .fault_seq(fault_seq8), .monitor(monitor8)
  );

  typedef struct { int pc; int hi; int post; int lo; } rec_t;
  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   prev_valid = 1'b0;
  bit   prev_hs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one acquisition cycle from an already-open PRE; ends by driving the closing phase_hi rise.
  task automatic body(input int pc, input int hi, input int post, input int lo, input bit ack_close);
    step(pc);
    sw_pc_ctl = SW_PC_SIGNAL;
    step(hi);
    sw_pc_ctl = SW_PC_BOOT;
    step(post);
    phase_hi = 1'b0;
    step(lo);
    phase_hi = 1'b1;
    if (ack_close) rec_ack = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, rec_valid, 0);
    chk({tag, "_pc"}, rec_pc, 0);
    chk({tag, "_hi"}, rec_hi, 0);
    chk({tag, "_post"}, rec_post, 0);
    chk({tag, "_lo"}, rec_lo, 0);
    chk({tag, "_cycles"}, cycle_count, 0);
    chk({tag, "_overruns"}, overrun_count, 0);
    chk({tag, "_ftimeout"}, fault_timeout, 0);
    chk({tag, "_fseq"}, fault_seq, 0);
    chk({tag, "_monitor"}, monitor, 0);
  endtask

  // Monitor: a new record is on the bus when rec_valid rises or stays high straight after a handshake.
  always @(negedge clk) begin
    rec_t e;
    if (!reset_n) begin
      if (rec_valid && (!prev_valid || prev_hs)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL rec_unexpected: got record pc=%0d hi=%0d expected none", rec_pc, rec_hi);
        end else begin
          e = exp_q.pop_front();
          chk("rec_pc", rec_pc, e.pc);
          chk("rec_hi", rec_hi, e.hi);
          chk("rec_post", rec_post, e.post);
          chk("rec_lo", rec_lo, e.lo);
        end
      end
      prev_valid = rec_valid;
      prev_hs    = rec_valid && rec_ack;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  initial begin
    step(3);
    chk_all_zero("reset");
    reset_n = 1'b0;
    step(3);
    chk("idle_to_sync", monitor[2:0], ST_SYNC);

    // Nominal cycle
    phase_hi = 1'b1;
    exp_q.push_back('{100, 1000, 100, 1000});
    body(100, 1000, 100, 1000, 1'b0);
    chk("valid_not_early", rec_valid, 0);
    step(1);
    chk("valid_latency", rec_valid, 1);
    chk("nominal_cycles", cycle_count, 1);
    chk("nominal_state_pre", monitor[2:0], ST_PRE);

    // Backpressure: second record dropped, first held
    body(49, 60, 70, 80, 1'b0);
    step(2);
    chk("bp_pc_held", rec_pc, 100);
    chk("bp_hi_held", rec_hi, 1000);
    chk("bp_post_held", rec_post, 100);
    chk("bp_lo_held", rec_lo, 1000);
    chk("bp_overruns", overrun_count, 1);
    chk("bp_cycles", cycle_count, 1);
    rec_ack = 1'b1;
    step(1);
    rec_ack = 1'b0;
    chk("ack_clears_valid", rec_valid, 0);

    // Fresh record, then a record accepted by an ack in the emit cycle
    exp_q.push_back('{30, 40, 50, 60});
    body(30 - 3, 40, 50, 60, 1'b0);
    step(1);
    exp_q.push_back('{11, 12, 13, 14});
    body(11 - 1, 12, 13, 14, 1'b1);
    step(1);
    rec_ack = 1'b0;
    chk("ack_emit_cycles", cycle_count, 3);
    chk("ack_emit_valid", rec_valid, 1);
    chk("ack_emit_overruns", overrun_count, 1);
    rec_ack = 1'b1;
    step(1);
    rec_ack = 1'b0;

    // Sequence fault: sw_pc rise during LO
    step(20);
    sw_pc_ctl = SW_PC_SIGNAL;
    step(30);
    sw_pc_ctl = SW_PC_BOOT;
    step(40);
    phase_hi = 1'b0;
    step(5);
    chk("seq_pre_state_lo", monitor[2:0], ST_LO);
    chk("seq_pre_flag", fault_seq, 0);
    sw_pc_ctl = SW_PC_SIGNAL;
    step(1);
    chk("seq_flag", fault_seq, 1);
    chk("seq_state_idle", monitor[2:0], ST_IDLE);
    chk("seq_no_record", rec_valid, 0);
    sw_pc_ctl = SW_PC_BOOT;
    step(2);
    chk("seq_resync", monitor[2:0], ST_SYNC);

    // Timeout in PRE at exactly p_timeout cycles
    p_timeout = 500;
    phase_hi = 1'b1;
    step(500);
    chk("to_not_early", fault_timeout, 0);
    chk("to_state_pre", monitor[2:0], ST_PRE);
    step(1);
    chk("to_flag", fault_timeout, 1);
    chk("to_state_idle", monitor[2:0], ST_IDLE);
    chk("to_seq_sticky", fault_seq, 1);
    chk("to_no_record", rec_valid, 0);
    chk("to_cycles", cycle_count, 3);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk("clr_timeout", fault_timeout, 0);
    chk("clr_seq", fault_seq, 0);
    p_timeout = '0;

    // Reset in the middle of HI with a pending record
    phase_hi = 1'b0;
    step(2);
    phase_hi = 1'b1;
    exp_q.push_back('{5, 6, 7, 8});
    body(5, 6, 7, 8, 1'b0);
    step(10);
    sw_pc_ctl = SW_PC_SIGNAL;
    step(10);
    chk("mid_hi_state", monitor[2:0], ST_HI);
    chk("mid_hi_cycles", cycle_count, 4);
    reset_n = 1'b1;
    step(1);
    chk_all_zero("midreset");
    reset_n = 1'b0;
    step(3);
    chk("post_reset_idle", monitor[2:0], ST_IDLE);
    sw_pc_ctl = SW_PC_BOOT;
    step(3);
    chk("idle_needs_ph_low", monitor[2:0], ST_IDLE);
    phase_hi = 1'b0;
    step(2);
    chk("post_reset_sync", monitor[2:0], ST_SYNC);
    phase_hi = 1'b1;
    exp_q.push_back('{7, 8, 9, 10});
    body(7, 8, 9, 10, 1'b0);
    step(2);
    chk("post_reset_cycles", cycle_count, 1);
    chk("post_reset_overruns", overrun_count, 0);

    // Saturation on the 8-bit instance
    ph8 = 1'b1;
    step(10);
    sw8 = SW_PC_SIGNAL;
    step(300);
    sw8 = SW_PC_BOOT;
    step(20);
    ph8 = 1'b0;
    step(30);
    ph8 = 1'b1;
    step(1);
    chk("sat_valid", rec_valid8, 1);
    chk("sat_pc", rec_pc8, 10);
    chk("sat_hi", rec_hi8, 255);
    chk("sat_post", rec_post8, 20);
    chk("sat_lo", rec_lo8, 30);
    chk("sat_cycles", cycle_count8, 1);
    chk("sat_overruns", overrun_count8, 0);
    chk("sat_faults", {fault_timeout8, fault_seq8}, 0);
    chk("sat_monitor", monitor8, 8'h22);

    step(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sample_phase_meter.md
Name: sample_phase_meter

Overview:
- Receive-side companion to the precharge/AZ acquisition sequencer.
- Watches the sequencer's pc-switch control (`sw_pc_ctl`) and hi-phase indicator (`phase_hi`, the sequencer's `monitor[0]`).
- Measures, in clk cycles, the duration of every phase of each acquisition cycle and emits one record per cycle over a valid/ack handshake to the SPI register bank.
- Flags timing faults (stalled sequencer, illegal edge order) so charge-injection runs can be trusted.

Parameters:
- W, 32, width of each phase counter and of `p_timeout`.
- CW, 16, width of the cycle and overrun counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-high reset (the name is kept as the codebase does; high = reset).
- sw_pc_ctl  in  1  sequencer pc switch (1 = SIGNAL, 0 = BOOT); same clock domain.
- phase_hi  in  1  1 while the AZ mux is on hi/PC-OUT; same clock domain.
- p_timeout  in  W  max cycles in any one phase; 0 disables the timeout.
- fault_clr  in  1  one-cycle pulse; clears the fault flags.
- rec_ack  in  1  consumer accepts the record while rec_valid = 1.
- rec_valid  out  1  record available.
- rec_pc  out  W  cycles from phase_hi rise to sw_pc_ctl rise (precharge).
- rec_hi  out  W  cycles sw_pc_ctl high (hi sample).
- rec_post  out  W  cycles from sw_pc_ctl fall to phase_hi fall.
- rec_lo  out  W  cycles from phase_hi fall to next phase_hi rise (lo sample).
- cycle_count  out  CW  records completed, wraps.
- overrun_count  out  CW  records dropped, saturates.
- fault_timeout  out  1  sticky.
- fault_seq  out  1  sticky.
- monitor  out  8  debug: [2:0] state, [3] rise event, [4] fall event, [5] rec_valid, [7:6] 0.

Behaviour:
- Reset: every output 0, state IDLE, counters 0, the input delay registers loaded with the current input values.
- Edge detect: `x_q` registers each input; rise = x & ~x_q, fall = ~x & x_q. An edge is seen on the cycle the input changes at the port.
- Phase counter: cleared to 1 on the edge that enters a measured state, then +1 per cycle. It saturates at all-ones and never wraps.
- Record field meaning: the field latched at the closing edge = (closing-edge cycle − opening-edge cycle).
- States and transitions:
  - IDLE: wait for phase_hi = 0 and sw_pc_ctl = 0 → SYNC.
  - SYNC: phase_hi rise → PRE.
  - PRE: sw_pc_ctl rise → latch pc, go HI.
  - HI: sw_pc_ctl fall → latch hi, go POST.
  - POST: phase_hi fall → latch post, go LO.
  - LO: phase_hi rise → latch lo, emit record, go PRE. This same edge opens the next PRE, so back-to-back cycles lose no clocks.
- Record emit:
  - rec_valid is 0 → fields load and rec_valid = 1 on the next cycle; cycle_count +1.
  - rec_valid is 1 and rec_ack is not asserted that cycle → new record dropped, old fields held, overrun_count +1.
  - rec_ack in the same cycle as an emit → new record accepted.
  - rec_ack while rec_valid = 1 and no emit → rec_valid = 0.
- Sequence fault (fault_seq = 1, go IDLE, partial record discarded):
  - sw_pc_ctl rise in POST, LO or SYNC;
  - sw_pc_ctl rise while phase_hi = 0;
  - phase_hi fall in PRE or HI.
- Timeout: p_timeout ≠ 0 and the phase counter reaches p_timeout in PRE/HI/POST/LO → fault_timeout = 1, go IDLE.
- Fault flags are sticky. fault_clr clears them; if a new fault occurs in the same cycle as fault_clr, the fault wins.
- Reset mid-operation: same as power-up. No record is emitted; measurement resumes only via IDLE → SYNC.

Decomposition:
- Shared package: state encoding (IDLE = 0, SYNC = 1, PRE = 2, HI = 3, POST = 4, LO = 5) and the SW_PC_SIGNAL/SW_PC_BOOT constants shared with the sequencer.
- One sub-module: `edge_det` (registered rise/fall detector), instantiated twice.

Test Plan:
- Nominal run: phase_hi rise @10, sw_pc rise @110, fall @1110, phase_hi fall @1210, rise @2210 → rec_pc = 100, rec_hi = 1000, rec_post = 100, rec_lo = 1000; rec_valid = 1 @2211; cycle_count = 1.
- Backpressure: repeat the nominal cycle twice with rec_ack held 0 → first record fields unchanged, overrun_count = 1, cycle_count = 1; one rec_ack pulse then clears rec_valid.
- Timeout: p_timeout = 500, phase_hi rises, sw_pc_ctl stays 0 → fault_timeout = 1 at 500 cycles into PRE, state IDLE, no record; fault_clr → flag 0.
- Sequence fault: sw_pc_ctl rises during LO with phase_hi = 0 → fault_seq = 1, state IDLE, rec_valid stays 0.
- Reset mid-HI: assert reset_n for 1 cycle → all outputs 0 next cycle; the next record needs phase_hi low, then a rise.
- Saturation with W = 8: 300-cycle hi phase → rec_hi = 255, other fields exact.
